vending_machine: RTL and testbench
==================================

# vending_machine

Single-product vending controller that accepts 5/10/25-unit coins, accumulates credit, and vends automatically once credit reaches the product price. It returns any overpayment as change in the same cycle. It sits between the coin-acceptor/button front end, which supplies one-cycle synchronous pulses, and the dispenser/change-return actuators. Internal state and credit are exposed under fixed names for hierarchical probing by benches.

## Interface
- PRICE, 25: product price in units; multiple of 5, range 5..30.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- coin5  in  1  5-unit coin present this cycle; sampled each rising edge.
- coin10  in  1  10-unit coin present this cycle.
- coin25  in  1  25-unit coin present this cycle.
- select  in  1  manual vend request.
- dispense  out  1  registered; high for exactly one cycle per vend.
- change  out  5  registered; change owed, valid only while dispense=1, otherwise 0.
- Probe names, fixed: current_state[1:0], next_state[1:0], total_amount[5:0] (unsigned credit).

## Operation
- States, encoding fixed:
  - IDLE=2'b00: credit 0.
  - COLLECT=2'b01: 0 < credit < PRICE.
  - DISPENSE=2'b10: vend cycle.
- Coin value per edge:
  - Level-sampled at each rising edge; each sampled-high cycle counts as one coin.
  - Simultaneous coin inputs: only the highest-priority coin is credited (coin25 > coin10 > coin5); the others are dropped.
- Coin accepted in IDLE/COLLECT, with sum = total_amount + coin value:
  - sum < PRICE: total_amount <= sum; next state COLLECT.
  - sum >= PRICE: next state DISPENSE; dispense <= 1; change <= sum - PRICE; total_amount <= sum.
- Select handling:
  - select in IDLE/COLLECT with total_amount >= PRICE: vend as above, with sum = total_amount.
  - select with total_amount < PRICE: ignored; no state or credit change.
  - select and a coin in the same cycle: the coin is processed and select is ignored.
- DISPENSE behaviour:
  - Lasts one cycle, then unconditionally goes to IDLE with total_amount <= 0, dispense <= 0, change <= 0.
  - Coins and select sampled during DISPENSE are ignored (lost).
- Arithmetic:
  - 6-bit unsigned; max sum = PRICE-5+25 <= 50; no overflow.
  - Change max 20, fits 5 bits.
- next_state is combinational from current_state, the coins, select and total_amount; current_state is registered.

## Timing
- Reset values (asserted asynchronously): current_state=IDLE, total_amount=0, dispense=0, change=0.
- Reset mid-transaction:
  - Accumulated credit is discarded with no change returned.
  - The first edge after deassertion already samples inputs.
- Coin-to-credit latency: coin high at edge N → total_amount updated after edge N.
- Vend latency:
  - Coin or select completing payment at edge N → dispense=1 and change valid from edge N to edge N+1.
  - Both return to 0 and state to IDLE after edge N+1.
- Back-to-back: a coin at edge N+2 starts a new transaction.
- Idle inputs hold all registers unchanged, with no timeout.

## Test plan
- Reset low 2 cycles, then high → state 00, total_amount 0, dispense 0, change 0; holds with no inputs.
- Exact payments:
  - coin25 pulse → dispense=1 for one cycle, change=0, then IDLE.
  - 5+10+10 in separate pulses → credit 5, 15, then dispense with change=0.
  - Five consecutive coin5 cycles → credit 5, 10, 15, 20, then dispense with change=0.
- Overpayments:
  - 10 then 25 → dispense, change=10.
  - 5, then select (ignored, credit stays 5, no dispense), then 25 → dispense, change=5.
- Simultaneous inputs:
  - coin5+coin10+coin25 in one cycle from IDLE → credited as 25 → dispense, change=0.
  - coin10 with select at credit 20 → dispense, change=5.
- Coin in the DISPENSE cycle is ignored and credit is 0 afterwards.
- Reset mid-transaction: 10 then 5 (credit 15), assert reset → credit 0, no dispense; after release, a 25 coin vends with change=0.

Source files
------------

// File: rtl/vending_machine.sv
// vending_machine: single-product coin-accumulating vend controller with change return
// ports: clk; reset (async, active-low); coin5/coin10/coin25/select one-cycle pulses in;
//        dispense (one-cycle vend strobe) and change (overpayment, valid only with dispense) out
module vending_machine #(
    parameter int unsigned PRICE = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin5,
    input  logic       coin10,
    input  logic       coin25,
    input  logic       select,
    output logic       dispense,
    output logic [4:0] change
);
    typedef enum logic [1:0] {IDLE = 2'b00, COLLECT = 2'b01, DISPENSE = 2'b10} state_t;
    localparam logic [5:0] P = 6'(PRICE);
    state_t     current_state, next_state;
    logic [5:0] total_amount, total_next, coin_val, sum;
    logic [4:0] change_next;
    logic       dispense_next, coin;
    always_comb begin
        coin_val = coin25 ? 6'd25 : coin10 ? 6'd10 : coin5 ? 6'd5 : 6'd0;
        coin = coin25 | coin10 | coin5;
        sum = total_amount + coin_val;
        next_state = current_state;
        total_next = total_amount;
        dispense_next = 1'b0;
        change_next = 5'd0;
        if (!(current_state inside {IDLE, COLLECT})) begin
            next_state = IDLE;
            total_next = 6'd0;
        end else if (coin || (select && total_amount >= P)) begin
            // with no coin, sum equals total_amount, so select vends through the same path
            total_next = sum;
            next_state = sum >= P ? DISPENSE : COLLECT;
            dispense_next = sum >= P;
            change_next = sum >= P ? 5'(sum - P) : 5'd0;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            current_state <= IDLE;
            total_amount <= 6'd0;
            dispense <= 1'b0;
            change <= 5'd0;
        end else begin
            current_state <= next_state;
            total_amount <= total_next;
            dispense <= dispense_next;
            change <= change_next;
        end
    end
endmodule

// File: tb/tb_vending_machine.sv
// tb_vending_machine: vector table, corner sequences and randomized model check of vending_machine
module tb_vending_machine;
    localparam int PRICE = 25;
    logic clk = 1'b0, reset = 1'b0;
    logic coin5 = 1'b0, coin10 = 1'b0, coin25 = 1'b0, select = 1'b0;
    logic dispense;
    logic [4:0] change;
    int n_cmp = 0, n_bad = 0;
    int m_credit = 0, m_change = 0;
    bit m_vend = 1'b0;

    vending_machine #(.PRICE(PRICE)) dut (
        .clk(clk), .reset(reset), .coin5(coin5), .coin10(coin10), .coin25(coin25),
        .select(select), .dispense(dispense), .change(change)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit c5, c10, c25, sel;
        int st, tot, dsp, chg;
    } vec_t;

    task automatic chk(input string nm, input int es, input int et, input int ed, input int ec);
        n_cmp++;
        if (int'(dut.current_state) != es || int'(dut.total_amount) != et ||
            int'(dispense) != ed || int'(change) != ec) begin
            n_bad++;
            $display("FAIL %s: got state=%0d total=%0d disp=%0d chg=%0d, want state=%0d total=%0d disp=%0d chg=%0d",
                     nm, dut.current_state, dut.total_amount, dispense, change, es, et, ed, ec);
        end
    endtask

    task automatic drive(input bit c5, input bit c10, input bit c25, input bit sel);
        @(negedge clk);
        coin5 = c5; coin10 = c10; coin25 = c25; select = sel;
        @(posedge clk);
        #1;
    endtask

    // reference: credit accumulates; once it reaches PRICE the next cycle is a vend, the one after clears
    task automatic model(input bit c5, input bit c10, input bit c25, input bit sel);
        int v;
        if (m_vend) begin
            m_vend = 1'b0; m_credit = 0; m_change = 0;
        end else begin
            v = c25 ? 25 : c10 ? 10 : c5 ? 5 : 0;
            if (v != 0 || (sel && m_credit >= PRICE)) begin
                m_credit += v;
                if (m_credit >= PRICE) begin
                    m_vend = 1'b1;
                    m_change = m_credit - PRICE;
                end
            end
        end
    endtask

    initial begin
        vec_t vt[$];
        vt = '{
            '{0,0,0,0, 0, 0,0, 0}, '{0,0,1,0, 2,25,1, 0}, '{0,0,0,0, 0, 0,0, 0},
            '{1,0,0,0, 1, 5,0, 0}, '{0,1,0,0, 1,15,0, 0}, '{0,1,0,0, 2,25,1, 0},
            '{0,0,0,0, 0, 0,0, 0}, '{1,0,0,0, 1, 5,0, 0}, '{1,0,0,0, 1,10,0, 0},
            '{1,0,0,0, 1,15,0, 0}, '{1,0,0,0, 1,20,0, 0}, '{1,0,0,0, 2,25,1, 0},
            '{0,0,0,0, 0, 0,0, 0}, '{0,1,0,0, 1,10,0, 0}, '{0,0,1,0, 2,35,1,10},
            '{0,0,0,0, 0, 0,0, 0}, '{1,0,0,0, 1, 5,0, 0}, '{0,0,0,1, 1, 5,0, 0},
            '{0,0,1,0, 2,30,1, 5}, '{0,0,0,0, 0, 0,0, 0}, '{1,1,1,0, 2,25,1, 0},
            '{0,0,0,0, 0, 0,0, 0}, '{0,1,0,0, 1,10,0, 0}, '{0,1,0,0, 1,20,0, 0},
            '{0,1,0,1, 2,30,1, 5}, '{0,0,1,0, 0, 0,0, 0}, '{0,0,0,0, 0, 0,0, 0},
            '{0,0,1,0, 2,25,1, 0}, '{0,1,0,1, 0, 0,0, 0}, '{0,0,1,0, 2,25,1, 0},
            '{0,0,0,0, 0, 0,0, 0}
        };
        repeat (2) @(posedge clk);
        #1;
        chk("reset_values", 0, 0, 0, 0);
        n_cmp++;
        if (dut.next_state != 2'b00) begin
            n_bad++;
            $display("FAIL reset_next_state: got %0d want 0", dut.next_state);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].c5, vt[i].c10, vt[i].c25, vt[i].sel);
            chk($sformatf("vec%0d", i), vt[i].st, vt[i].tot, vt[i].dsp, vt[i].chg);
        end
        // reset mid-collect discards credit asynchronously, no vend
        drive(0, 1, 0, 0);
        drive(1, 0, 0, 0);
        chk("pre_reset_credit", 1, 15, 0, 0);
        @(negedge clk);
        coin5 = 0; coin10 = 0;
        reset = 1'b0;
        #1;
        chk("async_reset_collect", 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        coin25 = 1'b1;
        @(posedge clk);
        #1;
        chk("first_edge_after_reset", 2, 25, 1, 0);
        drive(0, 0, 0, 0);
        chk("after_reset_vend_idle", 0, 0, 0, 0);
        // reset during the vend cycle clears dispense and change immediately
        drive(0, 1, 0, 0);
        drive(0, 0, 1, 0);
        chk("pre_reset_vend", 2, 35, 1, 10);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_dispense", 0, 0, 0, 0);
        @(negedge clk);
        coin25 = 0;
        reset = 1'b1;
        m_credit = 0; m_vend = 1'b0; m_change = 0;
        for (int i = 0; i < 3000; i++) begin
            bit c5, c10, c25, sel;
            c5 = $urandom_range(0, 3) == 0;
            c10 = $urandom_range(0, 4) == 0;
            c25 = $urandom_range(0, 7) == 0;
            sel = $urandom_range(0, 2) == 0;
            drive(c5, c10, c25, sel);
            model(c5, c10, c25, sel);
            chk($sformatf("rand%0d", i), m_vend ? 2 : (m_credit == 0 ? 0 : 1),
                m_credit, int'(m_vend), m_change);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
